// File: rtl/wbc_intercon_rr_pkg.sv
// wbc_intercon_rr_pkg: shared definitions for the round-robin control-bus
// interconnect. It holds the FSM state encoding, the watchdog counter width,
// the default control-bus slave map, and an index-width helper.
package wbc_intercon_rr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  localparam int TO_W = 8;

  // Default control-bus slave map (20-bit address space, 64 KiB windows)
  localparam logic [19:0] ID_CTRL_BASE = 20'h00000;
  localparam logic [19:0] HK_BASE      = 20'h10000;
  localparam logic [19:0] RFP_BASE     = 20'h20000;
  localparam logic [19:0] LAB4_BASE    = 20'h30000;
  localparam logic [19:0] WIN_MASK     = 20'hF0000;

  localparam logic [4*20-1:0] CB_SLV_BASE = {LAB4_BASE, RFP_BASE, HK_BASE, ID_CTRL_BASE};
  localparam logic [4*20-1:0] CB_SLV_MASK = {4{WIN_MASK}};

  // Width of an index into n items. This is never less than 1.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wbc_intercon_rr_if.sv
// wbc_intercon_rr_if: the bundle of master-side and slave-side WISHBONE
// signals around the interconnect.
//   slave  : view used by the interconnect. It takes master requests and
//            slave responses as inputs, and drives master responses and
//            slave strobes.
//   master : view used by the surrounding system. Every direction is the
//            opposite of the slave view.
interface wbc_intercon_rr_if #(
  parameter int NM = 3,
  parameter int NS = 4,
  parameter int AW = 20,
  parameter int DW = 32
);
  logic [NM-1:0]                m_cyc_i, m_stb_i, m_we_i;
  logic [NM-1:0][AW-1:0]        m_adr_i;
  logic [NM-1:0][DW-1:0]        m_dat_i;
  logic [NM-1:0][DW/8-1:0]      m_sel_i;
  logic [NM-1:0]                m_ack_o, m_err_o, m_rty_o;
  logic [NM-1:0][DW-1:0]        m_dat_o;
  logic [NS-1:0]                s_cyc_o, s_stb_o;
  logic                         s_we_o;
  logic [AW-1:0]                s_adr_o;
  logic [DW-1:0]                s_dat_o;
  logic [DW/8-1:0]              s_sel_o;
  logic [NS-1:0]                s_ack_i, s_err_i, s_rty_i;
  logic [NS-1:0][DW-1:0]        s_dat_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
    output m_ack_o, m_err_o, m_rty_o, m_dat_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    input  s_ack_i, s_err_i, s_rty_i, s_dat_i
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
    input  m_ack_o, m_err_o, m_rty_o, m_dat_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    output s_ack_i, s_err_i, s_rty_i, s_dat_i
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin request picker with a registered pointer.
//   clk_i, rst_i : clock and asynchronous active-high reset
//   req          : request vector
//   upd          : when high and a request wins, load the pointer with the winner
//   gnt, idx, vld: one-hot winner, winner index, and "some request present"
// The search starts at pointer+1 (mod NM). The pointer resets to NM-1, so
// master 0 wins the first arbitration.
module wb_rr_arbiter
  import wbc_intercon_rr_pkg::*;
#(
  parameter int NM = 3,
  parameter int IW = idx_w(NM)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [NM-1:0] req,
  input  logic          upd,
  output logic [NM-1:0] gnt,
  output logic [IW-1:0] idx,
  output logic          vld
);
  logic [IW-1:0] ptr;

  always_comb begin
    int c;
    c   = 0;
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    for (int i = 1; i <= NM; i++) begin
      c = (int'(ptr) + i) % NM;
      if (!vld && req[c]) begin
        vld    = 1'b1;
        gnt[c] = 1'b1;
        idx    = IW'(c);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)           ptr <= IW'(NM - 1);
    else if (upd && vld) ptr <= idx;
  end
endmodule

// File: rtl/wbc_intercon_rr.sv
// wbc_intercon_rr: shared-bus WISHBONE interconnect with NM masters and NS
// slaves. It provides round-robin arbitration with cyc-hold locking,
// base/mask decode, an error response for unmapped addresses, and a
// per-transfer watchdog.
//   clk_i, rst_i : wbc_clk and asynchronous active-high reset
//   bus          : all master and slave bus signals (slave modport)
//   grant_o      : one-hot current owner, registered
//   timeout_o    : one-cycle pulse when the watchdog expires
module wbc_intercon_rr
  import wbc_intercon_rr_pkg::*;
#(
  parameter int              NM       = 3,
  parameter int              NS       = 4,
  parameter int              AW       = 20,
  parameter int              DW       = 32,
  parameter logic [NS*AW-1:0] SLV_BASE = {NS*AW{1'b0}},
  parameter logic [NS*AW-1:0] SLV_MASK = {NS*AW{1'b0}},
  parameter int              TIMEOUT  = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  wbc_intercon_rr_if.slave  bus,
  output logic [NM-1:0]     grant_o,
  output logic              timeout_o
);
  localparam int MIW = idx_w(NM);
  localparam int SIW = idx_w(NS);

  state_t          state;
  logic [MIW-1:0]  gidx;
  logic [TO_W-1:0] wd_cnt;

  logic [NM-1:0]   arb_gnt;
  logic [MIW-1:0]  arb_idx;
  logic            arb_vld;

  wb_rr_arbiter #(.NM(NM), .IW(MIW)) u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req   (bus.m_cyc_i),
    .upd   (state == ST_IDLE),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .vld   (arb_vld)
  );

  // Signals of the granted master
  logic            gcyc, gstb, gwe;
  logic [AW-1:0]   gadr;
  logic [DW-1:0]   gdat;
  logic [DW/8-1:0] gsel;
  assign gcyc = bus.m_cyc_i[gidx];
  assign gstb = bus.m_stb_i[gidx];
  assign gwe  = bus.m_we_i[gidx];
  assign gadr = bus.m_adr_i[gidx];
  assign gdat = bus.m_dat_i[gidx];
  assign gsel = bus.m_sel_i[gidx];

  // Address decode. When several slaves hit, the lowest index wins.
  logic [NS-1:0]  raw_hit, hit_oh;
  logic [SIW-1:0] hit_idx;
  logic           any_hit;

  for (genvar k = 0; k < NS; k++) begin : g_dec
    assign raw_hit[k] = (gadr & SLV_MASK[k*AW +: AW]) ==
                        (SLV_BASE[k*AW +: AW] & SLV_MASK[k*AW +: AW]);
  end

  always_comb begin
    hit_oh  = '0;
    hit_idx = '0;
    any_hit = 1'b0;
    for (int k = 0; k < NS; k++) begin
      if (!any_hit && raw_hit[k]) begin
        any_hit   = 1'b1;
        hit_oh[k] = 1'b1;
        hit_idx   = SIW'(k);
      end
    end
  end

  // Response from the slave that was hit
  logic          r_ack, r_err, r_rty, resp, wd_fire;
  logic [DW-1:0] r_dat;
  assign r_ack = any_hit & bus.s_ack_i[hit_idx];
  assign r_err = any_hit & bus.s_err_i[hit_idx];
  assign r_rty = any_hit & bus.s_rty_i[hit_idx];
  assign r_dat = any_hit ? bus.s_dat_i[hit_idx] : '0;
  assign resp  = r_ack | r_err | r_rty;

  // A response in the expiry cycle suppresses the timeout
  assign wd_fire   = (state == ST_OWN) & gstb & ~resp & (wd_cnt == TO_W'(TIMEOUT));
  assign timeout_o = wd_fire;

  always_comb begin
    bus.s_cyc_o = '0;
    bus.s_stb_o = '0;
    bus.s_we_o  = 1'b0;
    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    bus.s_sel_o = '0;
    bus.m_ack_o = '0;
    bus.m_err_o = '0;
    bus.m_rty_o = '0;
    bus.m_dat_o = '0;
    if (state == ST_OWN) begin
      bus.s_cyc_o        = {NS{gcyc & ~wd_fire}} & hit_oh;
      bus.s_stb_o        = {NS{gstb & ~wd_fire}} & hit_oh;
      bus.s_we_o         = gwe;
      bus.s_adr_o        = gadr;
      bus.s_dat_o        = gdat;
      bus.s_sel_o        = gsel;
      bus.m_ack_o[gidx]  = r_ack;
      bus.m_err_o[gidx]  = r_err;
      bus.m_rty_o[gidx]  = r_rty;
      bus.m_dat_o[gidx]  = r_dat;
    end
    if (state == ST_ERR) bus.m_err_o[gidx] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      grant_o <= '0;
      gidx    <= '0;
      wd_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          wd_cnt <= '0;
          if (arb_vld) begin
            state   <= ST_OWN;
            grant_o <= arb_gnt;
            gidx    <= arb_idx;
          end
        end
        ST_OWN: begin
          if (!gcyc) begin
            state   <= ST_IDLE;
            grant_o <= '0;
            wd_cnt  <= '0;
          end else if (wd_fire || (gstb && !any_hit)) begin
            state  <= ST_ERR;
            wd_cnt <= '0;
          end else if (resp || !gstb) begin
            wd_cnt <= '0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        ST_ERR: begin
          // The err goes out this cycle whatever cyc does
          wd_cnt <= '0;
          if (gcyc) state <= ST_OWN;
          else begin
            state   <= ST_IDLE;
            grant_o <= '0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          grant_o <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wbc_intercon_rr.sv
module tb_wbc_intercon_rr;
  import wbc_intercon_rr_pkg::*;

  localparam int NM = 3, NS = 4, AW = 20, DW = 32;

  logic          clk, rst;
  logic [NM-1:0] grant;
  logic          tmo;

  wbc_intercon_rr_if #(.NM(NM), .NS(NS), .AW(AW), .DW(DW)) bus ();

  wbc_intercon_rr #(
    .NM(NM), .NS(NS), .AW(AW), .DW(DW),
    .SLV_BASE(CB_SLV_BASE), .SLV_MASK(CB_SLV_MASK), .TIMEOUT(16)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (bus),
    .grant_o   (grant),
    .timeout_o (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          m;
    logic [31:0] dat;
    bit          is_err;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input int m, input logic [31:0] d, input bit e);
    exp_t x;
    x.m = m; x.dat = d; x.is_err = e;
    sbq.push_back(x);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      chk({tag, ".unexpected"}, 64'(bus.m_ack_o | bus.m_err_o), 64'd0);
      return;
    end
    e = sbq.pop_front();
    if (e.is_err) chk({tag, ".err"}, 64'(bus.m_err_o), 64'd1 << e.m);
    else begin
      chk({tag, ".ack"}, 64'(bus.m_ack_o), 64'd1 << e.m);
      chk({tag, ".dat"}, 64'(bus.m_dat_o[e.m]), 64'(e.dat));
    end
  endtask

  task automatic m_start(input int m, input logic [19:0] a, input bit we, input logic [31:0] wd);
    bus.m_cyc_i[m] = 1'b1;
    bus.m_stb_i[m] = 1'b1;
    bus.m_we_i[m]  = we;
    bus.m_adr_i[m] = a;
    bus.m_dat_i[m] = wd;
    bus.m_sel_i[m] = 4'hF;
  endtask

  task automatic m_end(input int m);
    bus.m_cyc_i[m] = 1'b0;
    bus.m_stb_i[m] = 1'b0;
  endtask

  // Called in a cycle where slave sl is strobed: ack after dly cycles
  task automatic serve(input int sl, input int dly, input logic [31:0] rd, input string tag);
    chk({tag, ".stb"}, 64'(bus.s_stb_o), 64'd1 << sl);
    repeat (dly) begin
      @(negedge clk);
      chk({tag, ".noack"}, 64'(bus.m_ack_o), 64'd0);
    end
    bus.s_ack_i[sl] = 1'b1;
    bus.s_dat_i[sl] = rd;
    #1;
    pop_check(tag);
    @(negedge clk);
    bus.s_ack_i[sl] = 1'b0;
    bus.s_dat_i[sl] = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int order[4];
    int n;
    order = '{0, 1, 2, 0};
    rst = 1'b1;
    bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.m_we_i = '0;
    bus.m_adr_i = '0; bus.m_dat_i = '0; bus.m_sel_i = '0;
    bus.s_ack_i = '0; bus.s_err_i = '0; bus.s_rty_i = '0; bus.s_dat_i = '0;

    // Reset state
    @(negedge clk);
    chk("rst.grant", 64'(grant), 64'd0);
    chk("rst.scyc", 64'(bus.s_cyc_o), 64'd0);
    chk("rst.sstb", 64'(bus.s_stb_o), 64'd0);
    chk("rst.resp", 64'(bus.m_ack_o | bus.m_err_o | bus.m_rty_o), 64'd0);
    chk("rst.tmo", 64'(tmo), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: single read by master 0 from slave 0, ack 2 cycles after stb
    @(negedge clk);
    m_start(0, 20'h00010, 1'b0, '0);
    push(0, 32'hCAFE0001, 1'b0);
    #1 chk("t1.idle", 64'(grant), 64'd0);
    @(negedge clk);
    chk("t1.grant", 64'(grant), 64'b001);
    chk("t1.adr", 64'(bus.s_adr_o), 64'h00010);
    chk("t1.cyc", 64'(bus.s_cyc_o), 64'b0001);
    serve(0, 2, 32'hCAFE0001, "t1");
    m_end(0);
    @(negedge clk);
    chk("t1.release", 64'(grant), 64'd0);

    // 2: three masters contend and each does one transfer. Master 0 asks again.
    do_reset();
    @(negedge clk);
    for (int m = 0; m < 3; m++) begin
      m_start(m, 20'(m) << 16 | 20'h00020, 1'b0, '0);
      push(m, 32'hA0000000 | 32'(m), 1'b0);
    end
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      chk($sformatf("t2.grant%0d", r), 64'(grant), 64'd1 << order[r]);
      serve(order[r], 1, (r == 3) ? 32'hA0000030 : (32'hA0000000 | 32'(order[r])), "t2");
      m_end(order[r]);
      @(negedge clk);
      chk($sformatf("t2.gap%0d", r), 64'(grant), 64'd0);
      if (r == 0) begin
        m_start(0, 20'h00024, 1'b0, '0);
        push(0, 32'hA0000030, 1'b0);
      end
    end

    // 3: master 1 keeps cyc for 3 writes, and master 0 waits until it drops
    m_start(1, 20'h10100, 1'b1, 32'h11110000);
    m_start(0, 20'h00100, 1'b0, '0);
    for (int t = 0; t < 3; t++) push(1, 32'h0, 1'b0);
    push(0, 32'h00C0FFEE, 1'b0);
    @(negedge clk);
    for (int t = 0; t < 3; t++) begin
      bus.m_adr_i[1] = 20'h10100 + 20'(t * 4);
      bus.m_dat_i[1] = 32'h11110000 + 32'(t);
      #1;
      chk($sformatf("t3.grant%0d", t), 64'(grant), 64'b010);
      chk($sformatf("t3.wdat%0d", t), 64'(bus.s_dat_o), 64'h11110000 + 64'(t));
      chk($sformatf("t3.we%0d", t), 64'(bus.s_we_o), 64'd1);
      serve(1, 0, 32'h0, "t3");
    end
    m_end(1);
    @(negedge clk);
    chk("t3.gap", 64'(grant), 64'd0);
    @(negedge clk);
    chk("t3.grant0", 64'(grant), 64'b001);
    serve(0, 1, 32'h00C0FFEE, "t3b");
    m_end(0);
    @(negedge clk);

    // 4: unmapped write by master 2 gives one err cycle 2 cycles after stb
    m_start(2, 20'hF0000, 1'b1, 32'hDEADBEEF);
    push(2, 32'h0, 1'b1);
    @(negedge clk);
    chk("t4.grant", 64'(grant), 64'b100);
    chk("t4.nostb", 64'(bus.s_stb_o | bus.s_cyc_o), 64'd0);
    chk("t4.noerr", 64'(bus.m_err_o), 64'd0);
    @(negedge clk);
    pop_check("t4");
    chk("t4.nostb2", 64'(bus.s_stb_o), 64'd0);
    bus.m_stb_i[2] = 1'b0;
    @(negedge clk);
    chk("t4.errdone", 64'(bus.m_err_o), 64'd0);
    m_end(2);
    @(negedge clk);

    // 5: slave 3 never acks, and the watchdog fires after 16 strobed cycles
    m_start(0, 20'h30000, 1'b0, '0);
    push(0, 32'h0, 1'b1);
    @(negedge clk);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (tmo) break;
      if (bus.s_stb_o[3]) n++;
      @(negedge clk);
    end
    chk("t5.stbcycles", 64'(n), 64'd16);
    chk("t5.tmo", 64'(tmo), 64'd1);
    chk("t5.dropstb", 64'(bus.s_stb_o | bus.s_cyc_o), 64'd0);
    @(negedge clk);
    pop_check("t5");
    chk("t5.tmopulse", 64'(tmo), 64'd0);
    bus.m_stb_i[0] = 1'b0;
    @(negedge clk);
    m_start(0, 20'h00040, 1'b0, '0);
    push(0, 32'h5A5A0040, 1'b0);
    #1;
    serve(0, 1, 32'h5A5A0040, "t5b");
    m_end(0);
    @(negedge clk);

    // 6: reset while slave 1 is mid-transfer, then master 0 wins first
    m_start(1, 20'h10000, 1'b0, '0);
    m_start(0, 20'h00080, 1'b0, '0);
    @(negedge clk);
    chk("t6.grant", 64'(grant), 64'b010);
    chk("t6.stb", 64'(bus.s_stb_o), 64'b0010);
    #2;
    rst = 1'b1;
    bus.s_ack_i[1] = 1'b1;
    bus.s_dat_i[1] = 32'h12345678;
    #1;
    chk("t6.rst.grant", 64'(grant), 64'd0);
    chk("t6.rst.strobes", 64'(bus.s_stb_o | bus.s_cyc_o), 64'd0);
    chk("t6.rst.resp", 64'(bus.m_ack_o | bus.m_err_o | bus.m_rty_o), 64'd0);
    chk("t6.rst.dat", 64'(bus.m_dat_o[1]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.s_ack_i[1] = 1'b0;
    bus.s_dat_i[1] = '0;
    m_end(1);
    push(0, 32'h0BADF00D, 1'b0);
    @(negedge clk);
    chk("t6.first", 64'(grant), 64'b001);
    serve(0, 1, 32'h0BADF00D, "t6");
    m_end(0);
    @(negedge clk);
    chk("sb.drained", 64'(sbq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
